// File: rtl/online_pkg.sv
// ---------------------------------------------------------------------------
// online_pkg
// Shared definitions for the online arithmetic output stage.
//   - Signed-digit encodings for the (p,n) digit stream coming out of the
//     redundant adder cells: digit value = p - n.
//   - State encodings for the on-the-fly converter FSM.
//   - A small helper that folds the redundant (1,1) encoding onto zero so
//     downstream logic only has to deal with three canonical codes.
// ---------------------------------------------------------------------------
package online_pkg;

  // Canonical digit codes as {p, n}
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // (1,1) means +1 - 1 = 0, so it collapses onto the zero code.
  function automatic logic [1:0] digit_code(input logic p, input logic n);
    return (p && n) ? DIG_ZERO : {p, n};
  endfunction

endpackage

// File: rtl/otf_digit_update.sv
// ---------------------------------------------------------------------------
// otf_digit_update
// Purely combinational on-the-fly conversion step for one radix-2 signed
// digit. Given the running value Q and its companion QM = Q - 1 ulp, it
// appends the new digit and produces the next pair without any carry
// propagation: every case is just a left shift plus a selected LSB.
// Ports:
//   q, qm             in   W  current value and current value minus one ulp
//   p, n              in   1  signed digit bits, digit = p - n
//   q_next, qm_next   out  W  updated pair (MSB shifted out)
// ---------------------------------------------------------------------------
module otf_digit_update
  import online_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic         p,
  input  logic         n,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic [W-1:0] q_sh;
  logic [W-1:0] qm_sh;

  assign q_sh  = q << 1;
  assign qm_sh = qm << 1;

  // Select the next pair from the shifted Q/QM. A negative digit borrows
  // from Q, which is exactly what QM already holds, so no subtraction is
  // ever performed. The zero digit is the default so that (1,1) and any
  // other non-canonical code fall through to it.
  always_comb begin
    q_next  = q_sh;
    qm_next = qm_sh | W'(1);
    case (digit_code(p, n))
      DIG_POS: begin
        q_next  = q_sh | W'(1);
        qm_next = q_sh;
      end
      DIG_NEG: begin
        q_next  = qm_sh | W'(1);
        qm_next = qm_sh;
      end
      default: begin
        q_next  = q_sh;
        qm_next = qm_sh | W'(1);
      end
    endcase
  end

endmodule

// File: rtl/online_otf_converter.sv
// ---------------------------------------------------------------------------
// online_otf_converter
// Converts an MSD-first radix-2 signed-digit stream into an (N+1)-bit
// two's-complement word using on-the-fly conversion (Q / QM registers),
// so no carry-propagate adder sits on the output path.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    digit on in_p/in_n is valid
//   in_ready   out  1    converter accepts a digit this cycle
//   in_p       in   1    positive digit bit
//   in_n       in   1    negative digit bit, (1,1) decodes as zero
//   out_valid  out  1    result holds a completed conversion
//   out_ready  in   1    consumer accepts the result
//   result     out  N+1  converted value, zero while out_valid is low
// ---------------------------------------------------------------------------
module online_otf_converter
  import online_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_p,
  input  logic         in_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result
);

  localparam logic [CW-1:0] LAST = CW'(N);

  conv_state_t   state;
  conv_state_t   state_nxt;
  logic [N:0]    q;
  logic [N:0]    qm;
  logic [N:0]    q_nxt;
  logic [N:0]    qm_nxt;
  logic [N:0]    q_upd;
  logic [N:0]    qm_upd;
  logic [N:0]    result_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic          xfer;

  otf_digit_update #(
    .W(N + 1)
  ) u_update (
    .q      (q),
    .qm     (qm),
    .p      (in_p),
    .n      (in_n),
    .q_next (q_upd),
    .qm_next(qm_upd)
  );

  // The converter never overlaps a new conversion with the result
  // handshake, so readiness and result validity are both pure functions
  // of the registered state.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign xfer      = in_valid && in_ready;
  assign cnt_inc   = cnt + CW'(1);

  // Next-state logic. IDLE and CONV behave identically for a transfer;
  // IDLE exists so the first digit starts from the reset pair Q=0,
  // QM=all ones. The result register is loaded with the final Q in the
  // same cycle the FSM enters DONE, and cleared on the way back to IDLE.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    qm_nxt     = qm;
    cnt_nxt    = cnt;
    result_nxt = result;
    case (state)
      IDLE, CONV: begin
        if (xfer) begin
          q_nxt   = q_upd;
          qm_nxt  = qm_upd;
          cnt_nxt = cnt_inc;
          if (cnt_inc == LAST) begin
            state_nxt  = DONE;
            result_nxt = q_upd;
          end else begin
            state_nxt = CONV;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt  = IDLE;
          q_nxt      = '0;
          qm_nxt     = '1;
          cnt_nxt    = '0;
          result_nxt = '0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        q_nxt      = '0;
        qm_nxt     = '1;
        cnt_nxt    = '0;
        result_nxt = '0;
      end
    endcase
  end

  // State, counter and conversion registers. Reset is asynchronous so an
  // abort mid-conversion drops out_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      qm     <= '1;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      qm     <= qm_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// ---------------------------------------------------------------------------
// tb_online_otf_converter
// Directed bench for the on-the-fly converter. A 4-digit instance runs a
// table of digit vectors plus hand-written handshake/bubble/reset
// sequences; an 8-digit instance converts random digit streams checked
// against an integer reference sum.
// ---------------------------------------------------------------------------
module tb_online_otf_converter;

  logic       clk;
  logic       rst;

  logic       in_valid4;
  logic       in_ready4;
  logic       in_p4;
  logic       in_n4;
  logic       out_valid4;
  logic       out_ready4;
  logic [4:0] result4;

  logic       in_valid8;
  logic       in_ready8;
  logic       in_p8;
  logic       in_n8;
  logic       out_valid8;
  logic       out_ready8;
  logic [8:0] result8;

  int compared;
  int mismatched;

  typedef struct {
    string      name;
    logic [7:0] digs;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  online_otf_converter #(.N(4), .CW(3)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .in_p     (in_p4),
    .in_n     (in_n4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .result   (result4)
  );

  online_otf_converter #(.N(8), .CW(4)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_p     (in_p8),
    .in_n     (in_n8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .result   (result8)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer four digits back to back ({p,n} pairs, first digit in the MSBs)
  task automatic applyStimulus(input logic [7:0] digs);
    for (int i = 0; i < 4; i++) begin
      {in_p4, in_n4} = digs[7-2*i -: 2];
      in_valid4 = 1'b1;
      tick();
    end
    in_valid4 = 1'b0;
    {in_p4, in_n4} = 2'b00;
  endtask

  // Stream eight random digits into the wide instance and check the result
  task automatic runRandom8(input int idx);
    int          sum;
    logic [1:0]  code;
    logic [8:0]  exp;
    sum = 0;
    for (int i = 1; i <= 8; i++) begin
      code = 2'($urandom_range(0, 3));
      if (code == 2'b10) sum += (1 << (8 - i));
      else if (code == 2'b01) sum -= (1 << (8 - i));
      {in_p8, in_n8} = code;
      in_valid8 = 1'b1;
      tick();
    end
    in_valid8 = 1'b0;
    exp = 9'(sum);
    checkOutput($sformatf("rand8_%0d_valid", idx), 16'(out_valid8), 16'd1);
    checkOutput($sformatf("rand8_%0d_result", idx), 16'(result8), 16'(exp));
    tick();
    checkOutput($sformatf("rand8_%0d_idle", idx), 16'(out_valid8), 16'd0);
  endtask

  initial begin
    logic [1:0]  bub_digs [4];
    logic        bub_valid [7];
    int          di;

    compared   = 0;
    mismatched = 0;

    vecs[0] = '{"pos_neg_zero_pos", 8'b10_01_00_10, 5'b00101};
    vecs[1] = '{"all_neg",          8'b01_01_01_01, 5'b10001};
    vecs[2] = '{"all_pos",          8'b10_10_10_10, 5'b01111};
    vecs[3] = '{"zero_with_11",     8'b00_11_00_00, 5'b00000};
    vecs[4] = '{"pp_nn",            8'b10_10_01_01, 5'b01001};
    vecs[5] = '{"minus_one_a",      8'b01_10_10_10, 5'b11111};
    vecs[6] = '{"minus_one_b",      8'b00_00_00_01, 5'b11111};
    vecs[7] = '{"plus_eight",       8'b10_00_00_00, 5'b01000};

    rst        = 1'b1;
    in_valid4  = 1'b0;
    in_p4      = 1'b0;
    in_n4      = 1'b0;
    out_ready4 = 1'b1;
    in_valid8  = 1'b0;
    in_p8      = 1'b0;
    in_n8      = 1'b0;
    out_ready8 = 1'b1;

    // Reset state
    #3;
    checkOutput("reset_out_valid", 16'(out_valid4), 16'd0);
    checkOutput("reset_in_ready",  16'(in_ready4),  16'd1);
    checkOutput("reset_result",    16'(result4),    16'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven conversions with out_ready held high
    for (int v = 0; v < 8; v++) begin
      checkOutput({vecs[v].name, "_pre_ready"}, 16'(in_ready4),  16'd1);
      checkOutput({vecs[v].name, "_pre_valid"}, 16'(out_valid4), 16'd0);
      applyStimulus(vecs[v].digs);
      checkOutput({vecs[v].name, "_valid"},  16'(out_valid4), 16'd1);
      checkOutput({vecs[v].name, "_result"}, 16'(result4),    16'(vecs[v].exp));
      checkOutput({vecs[v].name, "_busy"},   16'(in_ready4),  16'd0);
      tick();
      checkOutput({vecs[v].name, "_released"},  16'(out_valid4), 16'd0);
      checkOutput({vecs[v].name, "_cleared"},   16'(result4),    16'd0);
    end

    // Backpressure: result held, offered digits ignored
    out_ready4 = 1'b0;
    applyStimulus(8'b10_01_00_10);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_valid_%0d", c),  16'(out_valid4), 16'd1);
      checkOutput($sformatf("bp_result_%0d", c), 16'(result4),    16'd5);
      checkOutput($sformatf("bp_ready_%0d", c),  16'(in_ready4),  16'd0);
      in_valid4 = 1'b1;
      {in_p4, in_n4} = 2'b10;
      tick();
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    tick();
    checkOutput("bp_release_valid", 16'(out_valid4), 16'd0);
    checkOutput("bp_release_ready", 16'(in_ready4),  16'd1);
    applyStimulus(8'b00_00_00_10);
    checkOutput("bp_after_result", 16'(result4), 16'd1);
    tick();

    // Bubbles: valid pattern 1,0,0,1,1,0,1 over digits +1,+1,-1,-1
    bub_digs  = '{2'b10, 2'b10, 2'b01, 2'b01};
    bub_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    di = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid4 = bub_valid[c];
      if (bub_valid[c]) begin
        {in_p4, in_n4} = bub_digs[di];
        di++;
      end else begin
        {in_p4, in_n4} = 2'b01;
      end
      if (c < 6) begin
        tick();
        checkOutput($sformatf("bubble_not_done_%0d", c), 16'(out_valid4), 16'd0);
      end else begin
        tick();
      end
    end
    in_valid4 = 1'b0;
    checkOutput("bubble_valid",  16'(out_valid4), 16'd1);
    checkOutput("bubble_result", 16'(result4),    16'b01001);
    tick();

    // Asynchronous reset after two digits, then a clean conversion
    in_valid4 = 1'b1;
    {in_p4, in_n4} = 2'b10;
    tick();
    tick();
    in_valid4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 16'(out_valid4), 16'd0);
    checkOutput("rst_mid_ready", 16'(in_ready4),  16'd1);
    #1 rst = 1'b0;
    tick();
    in_valid4 = 1'b1;
    {in_p4, in_n4} = 2'b01;
    tick();
    {in_p4, in_n4} = 2'b00;
    tick();
    tick();
    checkOutput("rst_after_not_early", 16'(out_valid4), 16'd0);
    {in_p4, in_n4} = 2'b10;
    tick();
    in_valid4 = 1'b0;
    checkOutput("rst_after_valid",  16'(out_valid4), 16'd1);
    checkOutput("rst_after_result", 16'(result4),    16'b11001);
    tick();

    // Asynchronous reset while holding a result
    out_ready4 = 1'b0;
    applyStimulus(8'b10_10_10_10);
    checkOutput("rst_done_hold", 16'(out_valid4), 16'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_done_valid",  16'(out_valid4), 16'd0);
    checkOutput("rst_done_result", 16'(result4),    16'd0);
    checkOutput("rst_done_ready",  16'(in_ready4),  16'd1);
    #1 rst = 1'b0;
    out_ready4 = 1'b1;
    tick();

    // Eight-digit instance against the reference sum
    for (int r = 0; r < 6; r++) begin
      runRandom8(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
